// File: rtl/ysyx_22040632_div_pkg.sv
//==============================================================================
// Module      : ysyx_22040632_div_pkg
// Description : Shared types and constants for the RV64M divide requester.
// Revision    : 1.0
//==============================================================================
`default_nettype none

package ysyx_22040632_div_pkg;

    typedef enum logic [1:0] {
        OP_DIV  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REM  = 2'b10,
        OP_REMU = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_HOLD = 2'd2
    } div_state_e;

    localparam logic [63:0] INT64_MIN = 64'h8000_0000_0000_0000;
    localparam logic [31:0] INT32_MIN = 32'h8000_0000;

    // op[0] set marks the unsigned forms, op[1] set marks the remainder forms
    function automatic logic op_is_signed(input logic [1:0] op);
        return (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic op_is_rem(input logic [1:0] op);
        return (op == OP_REM) || (op == OP_REMU);
    endfunction

endpackage

`default_nettype wire

// File: rtl/ysyx_22040632_div_special.sv
//==============================================================================
// Module      : ysyx_22040632_div_special
// Description : Combinational detection and result of divide-by-zero and
//               signed overflow, including W-form sign extension.
// Revision    : 1.0
//==============================================================================
`default_nettype none

module ysyx_22040632_div_special
    import ysyx_22040632_div_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [1:0]      op,
    input  logic            word,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    output logic            hit,
    output logic [XLEN-1:0] result
);

    logic            w_zero;
    logic            w_ovf;
    logic [XLEN-1:0] w_quot;
    logic [XLEN-1:0] w_rem;
    logic [XLEN-1:0] w_sel;

    always_comb begin
        w_zero = word ? (src2[31:0] == 32'd0) : (src2 == '0);
        w_ovf  = op_is_signed(op) &&
                 (word ? ((src1[31:0] == INT32_MIN) && (src2[31:0] == 32'hFFFF_FFFF))
                       : ((src1 == INT64_MIN) && (src2 == {XLEN{1'b1}})));
        hit    = w_zero || w_ovf;

        // Zero divisor wins: its quotient/remainder pair is defined regardless of sign
        if (w_zero) begin
            w_quot = {XLEN{1'b1}};
            w_rem  = src1;
        end else begin
            w_quot = src1;
            w_rem  = '0;
        end

        w_sel  = op_is_rem(op) ? w_rem : w_quot;
        result = word ? {{(XLEN-32){w_sel[31]}}, w_sel[31:0]} : w_sel;
    end

endmodule

`default_nettype wire

// File: rtl/ysyx_22040632_div_req.sv
//==============================================================================
// Module      : ysyx_22040632_div_req
// Description : Divider initiator: decodes RV64M divides, short-circuits
//               special cases, launches the iterative divider, holds result.
// Revision    : 1.0
//==============================================================================
`default_nettype none

module ysyx_22040632_div_req
    import ysyx_22040632_div_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rrst_n,
    // issue side
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      in_op,
    input  logic            in_word,
    input  logic [XLEN-1:0] in_src1,
    input  logic [XLEN-1:0] in_src2,
    input  logic            flush,
    // writeback side
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_data,
    // divider side
    output logic            div_valid,
    input  logic            div_ready,
    output logic            div_flush,
    output logic            divw,
    output logic            div_signed,
    output logic [XLEN-1:0] dividend,
    output logic [XLEN-1:0] divisor,
    input  logic            div_out_valid,
    input  logic [XLEN-1:0] quotient,
    input  logic [XLEN-1:0] remainder
);

    localparam logic [1:0] S_IDLE = ST_IDLE;
    localparam logic [1:0] S_BUSY = ST_BUSY;
    localparam logic [1:0] S_HOLD = ST_HOLD;

    logic [1:0]      r_state;
    logic [1:0]      r_op;
    logic            r_word;
    logic [XLEN-1:0] r_data;

    logic            w_hit;
    logic [XLEN-1:0] w_special_result;
    logic            w_accept;
    logic [XLEN-1:0] w_div_sel;
    logic [XLEN-1:0] w_div_result;

    ysyx_22040632_div_special #(
        .XLEN   (XLEN)
    ) u_special (
        .op     (in_op),
        .word   (in_word),
        .src1   (in_src1),
        .src2   (in_src2),
        .hit    (w_hit),
        .result (w_special_result)
    );

    // Launch is only offered when the divider can take it this very cycle
    always_comb begin
        in_ready   = (r_state == S_IDLE) && !flush && (w_hit || div_ready);
        w_accept   = in_valid && in_ready;
        div_valid  = w_accept && !w_hit;
        div_flush  = flush && (r_state == S_BUSY);
        divw       = in_word;
        div_signed = op_is_signed(in_op);
        dividend   = in_src1;
        divisor    = in_src2;
        out_valid  = (r_state == S_HOLD);
        out_data   = r_data;
    end

    always_comb begin
        w_div_sel    = op_is_rem(r_op) ? remainder : quotient;
        w_div_result = r_word ? {{(XLEN-32){w_div_sel[31]}}, w_div_sel[31:0]} : w_div_sel;
    end

    // div_out_valid is only honoured in BUSY, so late or stale pulses seen in IDLE are dropped
    always_ff @(posedge clk or negedge rrst_n) begin
        if (!rrst_n) begin
            r_state <= S_IDLE;
            r_op    <= 2'b00;
            r_word  <= 1'b0;
            r_data  <= '0;
        end else if (flush) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op   <= in_op;
                        r_word <= in_word;
                        if (w_hit) begin
                            r_data  <= w_special_result;
                            r_state <= S_HOLD;
                        end else begin
                            r_state <= S_BUSY;
                        end
                    end
                end
                S_BUSY: begin
                    if (div_out_valid) begin
                        r_data  <= w_div_result;
                        r_state <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire
